euler_sequencer: RTL and testbench

Run controller for the Project Euler solver cores. It holds every solver (p-style core: `result[31:0]`, `done`, `error`) in synchronous reset, then releases them one at a time in index order. For each solver it waits for `done`, `error` or a timeout, and records the result, status and run-cycle count into a small register bank. It sits above the solver instances in the top level and replaces per-solver benches for batch runs.

---
 rtl/euler_pkg.sv | 26 ++
 rtl/euler_result_bank.sv | 37 +++
 rtl/euler_sequencer.sv | 162 ++++++++++++++++
 tb/tb_euler_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/euler_pkg.sv
// Shared types and constants for the Project Euler run sequencer.
package euler_pkg;

  localparam int unsigned RESULT_W = 32;
  localparam int unsigned IDX_W    = 5;

  localparam logic [1:0] ST_NONE    = 2'd0;
  localparam logic [1:0] ST_DONE    = 2'd1;
  localparam logic [1:0] ST_ERROR   = 2'd2;
  localparam logic [1:0] ST_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_HOLD,
    S_RUN,
    S_FINISHED
  } seq_state_e;

  typedef struct packed {
    logic [RESULT_W-1:0] result;
    logic [1:0]          status;
    logic [31:0]         cycles;
  } bank_entry_t;

endpackage

// File: rtl/euler_result_bank.sv
// Per-solver result/status/cycle register file: one write port, combinational read, sync clear.
module euler_result_bank
  import euler_pkg::*;
#(
  parameter int unsigned N_SOLVERS = 4
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  bank_entry_t      wr_data_i,
  input  logic [3:0]       rd_idx_i,
  output bank_entry_t      rd_data_o
);

  bank_entry_t entry_q [N_SOLVERS];

  always_ff @(posedge clk) begin
    if (rst_i || clr_i) begin
      for (int unsigned i = 0; i < N_SOLVERS; i++) entry_q[i] <= '0;
    end else if (we_i) begin
      for (int unsigned i = 0; i < N_SOLVERS; i++) begin
        if (wr_idx_i == IDX_W'(i)) entry_q[i] <= wr_data_i;
      end
    end
  end

  // Indices beyond the populated entries fall through to the all-zero default.
  always_comb begin
    rd_data_o = '0;
    for (int unsigned i = 0; i < N_SOLVERS; i++) begin
      if (rd_idx_i == 4'(i)) rd_data_o = entry_q[i];
    end
  end

endmodule

// File: rtl/euler_sequencer.sv
// Batch run controller: releases solver cores one at a time and records their outcome.
module euler_sequencer
  import euler_pkg::*;
#(
  parameter int unsigned N_SOLVERS      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned RST_CYCLES     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N_SOLVERS-1:0]          solver_en,
  output logic [N_SOLVERS-1:0]          solver_rst,
  input  logic [N_SOLVERS-1:0]          solver_done,
  input  logic [N_SOLVERS-1:0]          solver_error,
  input  logic [RESULT_W*N_SOLVERS-1:0] solver_result,
  input  logic [3:0]                    rd_idx,
  output logic [RESULT_W-1:0]           rd_result,
  output logic [1:0]                    rd_status,
  output logic [31:0]                   rd_cycles,
  output logic                          busy,
  output logic                          all_done
);

  seq_state_e           state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_SOLVERS-1:0] mask_q, mask_d;
  logic [31:0]          hold_q, hold_d;
  logic [31:0]          cyc_q, cyc_d;

  logic                 start_acc;
  logic                 sel_en, sel_err, sel_done, run_tmo, run_exit;
  logic [RESULT_W-1:0]  sel_result;
  logic [N_SOLVERS-1:0] sel_onehot;

  logic                 wr_en;
  bank_entry_t          wr_data, rd_data;

  assign start_acc = start && (state_q == S_IDLE || state_q == S_FINISHED);

  always_comb begin
    sel_en     = 1'b0;
    sel_err    = 1'b0;
    sel_done   = 1'b0;
    sel_result = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < N_SOLVERS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_en        = mask_q[i];
        sel_err       = solver_error[i];
        sel_done      = solver_done[i];
        sel_result    = solver_result[RESULT_W*i +: RESULT_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign run_tmo  = (cyc_q == 32'(TIMEOUT_CYCLES));
  assign run_exit = (state_q == S_RUN) && (sel_err || sel_done || run_tmo);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      hold_q  <= '0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    unique case (state_q)
      S_IDLE, S_FINISHED: begin
        if (start) begin
          mask_d  = solver_en;
          idx_d   = '0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        if (idx_q >= IDX_W'(N_SOLVERS)) begin
          state_d = S_FINISHED;
        end else if (!sel_en) begin
          idx_d = idx_q + 1'b1;
        end else begin
          hold_d  = '0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_q == 32'(RST_CYCLES - 1)) begin
          cyc_d   = 32'd1;
          state_d = S_RUN;
        end else begin
          hold_d = hold_q + 32'd1;
        end
      end
      S_RUN: begin
        if (run_exit) begin
          idx_d   = idx_q + 1'b1;
          state_d = S_SELECT;
        end else begin
          cyc_d = cyc_q + 32'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // error outranks done, which outranks timeout; only a pure timeout zeroes the result
  always_comb begin
    solver_rst = '1;
    busy       = (state_q != S_IDLE) && (state_q != S_FINISHED);
    all_done   = (state_q == S_FINISHED);
    wr_en      = 1'b0;
    wr_data    = '0;
    if (state_q == S_RUN) begin
      solver_rst     = ~sel_onehot;
      wr_en          = run_exit;
      wr_data.cycles = cyc_q;
      if (sel_err) begin
        wr_data.status = ST_ERROR;
        wr_data.result = sel_result;
      end else if (sel_done) begin
        wr_data.status = ST_DONE;
        wr_data.result = sel_result;
      end else begin
        wr_data.status = ST_TIMEOUT;
        wr_data.result = '0;
      end
    end
  end

  euler_result_bank #(
    .N_SOLVERS(N_SOLVERS)
  ) u_bank (
    .clk       (clk),
    .rst_i     (rst),
    .clr_i     (start_acc),
    .we_i      (wr_en),
    .wr_idx_i  (idx_q),
    .wr_data_i (wr_data),
    .rd_idx_i  (rd_idx),
    .rd_data_o (rd_data)
  );

  assign rd_result = rd_data.result;
  assign rd_status = rd_data.status;
  assign rd_cycles = rd_data.cycles;

endmodule

// File: tb/tb_euler_sequencer.sv
// Directed bench for euler_sequencer driving four stub solvers with per-solver latency/result.
module tb_euler_sequencer;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   solver_en;
  logic [3:0]   solver_rst;
  logic [3:0]   solver_done;
  logic [3:0]   solver_error;
  logic [127:0] solver_result;
  logic [3:0]   rd_idx;
  logic [31:0]  rd_result;
  logic [1:0]   rd_status;
  logic [31:0]  rd_cycles;
  logic         busy;
  logic         all_done;

  int unsigned dly  [4];
  logic [31:0] res  [4];
  logic        errf [4];
  logic [31:0] scnt [4];

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] order;
  int          nrel;
  int          overlap;

  always #5 clk = ~clk;

  euler_sequencer #(
    .N_SOLVERS      (4),
    .TIMEOUT_CYCLES (20),
    .RST_CYCLES     (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .solver_en     (solver_en),
    .solver_rst    (solver_rst),
    .solver_done   (solver_done),
    .solver_error  (solver_error),
    .solver_result (solver_result),
    .rd_idx        (rd_idx),
    .rd_result     (rd_result),
    .rd_status     (rd_status),
    .rd_cycles     (rd_cycles),
    .busy          (busy),
    .all_done      (all_done)
  );

  // Stub solvers: count cycles out of reset, raise done after dly cycles (dly=0 never finishes).
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (solver_rst[i]) scnt[i] <= '0;
      else               scnt[i] <= scnt[i] + 32'd1;
    end
  end

  always_comb begin
    solver_done   = '0;
    solver_error  = '0;
    solver_result = '0;
    for (int i = 0; i < 4; i++) begin
      solver_result[32*i +: 32] = res[i];
      if (!solver_rst[i] && dly[i] != 0 && scnt[i] >= dly[i] - 1) begin
        solver_done[i]  = 1'b1;
        solver_error[i] = errf[i];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_batch(input logic [3:0] mask);
    solver_en = mask;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic set_stub(input int i, input int unsigned d, input logic [31:0] r, input logic e);
    dly[i]  = d;
    res[i]  = r;
    errf[i] = e;
  endtask

  task automatic run_batch(input int budget, output logic [15:0] ord, output int nr, output int ovl);
    logic [3:0] prev;
    int n;
    prev = solver_rst;
    ord  = '0;
    nr   = 0;
    ovl  = 0;
    n    = 0;
    while (!all_done && n < budget) begin
      tick();
      n++;
      for (int i = 0; i < 4; i++) begin
        if (prev[i] && !solver_rst[i]) begin
          ord = {ord[11:0], 4'(i)};
          nr++;
        end
      end
      if ($countones(~solver_rst) > 1) ovl++;
      prev = solver_rst;
    end
    check("batch_finish", 32'(all_done), 32'd1);
  endtask

  task automatic wait_rst(input logic [3:0] pat, input int budget);
    int n;
    n = 0;
    while (solver_rst !== pat && n < budget) begin
      tick();
      n++;
    end
    check("wait_rst", 32'(solver_rst), 32'(pat));
  endtask

  task automatic read_entry(input string tag, input logic [3:0] idx, input logic [31:0] er,
                            input logic [1:0] es, input logic [31:0] ec);
    rd_idx = idx;
    #1;
    check({tag, "_res"}, rd_result, er);
    check({tag, "_st"},  32'(rd_status), 32'(es));
    check({tag, "_cyc"}, rd_cycles, ec);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; solver_en = '0; rd_idx = '0;
    for (int i = 0; i < 4; i++) set_stub(i, 0, 32'd0, 1'b0);
    tick(); tick();
    check("rst_solver_rst", 32'(solver_rst), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_all_done", 32'(all_done), 32'd0);
    read_entry("rst_b0", 4'd0, 32'd0, 2'd0, 32'd0);
    rst = 1'b0;
    tick();

    // Single solver: release timing and a done after 10 cycles
    set_stub(0, 10, 32'd31875000, 1'b0);
    start_batch(4'b0001);
    check("t1_busy", 32'(busy), 32'd1);
    tick();
    check("t1_hold_a", 32'(solver_rst), 32'hF);
    tick();
    check("t1_hold_b", 32'(solver_rst), 32'hF);
    tick();
    check("t1_release", 32'(solver_rst), 32'hE);
    run_batch(100, order, nrel, overlap);
    check("t1_all_done", 32'(all_done), 32'd1);
    check("t1_busy_end", 32'(busy), 32'd0);
    read_entry("t1_b0", 4'd0, 32'd31875000, 2'd1, 32'd10);

    // Four solvers in order, one at a time
    set_stub(0, 3, 32'd1, 1'b0);
    set_stub(1, 5, 32'd2, 1'b0);
    set_stub(2, 1, 32'd3, 1'b0);
    set_stub(3, 7, 32'd4, 1'b0);
    start_batch(4'hF);
    run_batch(200, order, nrel, overlap);
    check("t2_order", 32'(order), 32'h0123);
    check("t2_nrel", 32'(nrel), 32'd4);
    check("t2_overlap", 32'(overlap), 32'd0);
    read_entry("t2_b0", 4'd0, 32'd1, 2'd1, 32'd3);
    read_entry("t2_b1", 4'd1, 32'd2, 2'd1, 32'd5);
    read_entry("t2_b2", 4'd2, 32'd3, 2'd1, 32'd1);
    read_entry("t2_b3", 4'd3, 32'd4, 2'd1, 32'd7);

    // done+error together, then a solver that never finishes
    set_stub(1, 2, 32'hDEAD, 1'b1);
    set_stub(2, 0, 32'h55, 1'b0);
    start_batch(4'b0110);
    run_batch(200, order, nrel, overlap);
    read_entry("t3_b1", 4'd1, 32'hDEAD, 2'd2, 32'd2);
    read_entry("t3_b2", 4'd2, 32'd0, 2'd3, 32'd20);
    read_entry("t3_b0", 4'd0, 32'd0, 2'd0, 32'd0);

    // Restart from FINISHED clears the bank; sparse mask skips solvers
    set_stub(0, 4, 32'h10, 1'b0);
    set_stub(1, 6, 32'h11, 1'b0);
    set_stub(2, 2, 32'h12, 1'b0);
    set_stub(3, 3, 32'h13, 1'b0);
    start_batch(4'b1010);
    read_entry("t4_clr_b1", 4'd1, 32'd0, 2'd0, 32'd0);
    run_batch(200, order, nrel, overlap);
    check("t4_order", 32'(order), 32'h0013);
    check("t4_nrel", 32'(nrel), 32'd2);
    read_entry("t4_b0", 4'd0, 32'd0, 2'd0, 32'd0);
    read_entry("t4_b1", 4'd1, 32'h11, 2'd1, 32'd6);
    read_entry("t4_b2", 4'd2, 32'd0, 2'd0, 32'd0);
    read_entry("t4_b3", 4'd3, 32'h13, 2'd1, 32'd3);

    // All-zero mask: N+1 SELECT cycles then FINISHED
    start_batch(4'b0000);
    tick(); tick(); tick(); tick();
    check("t5_not_yet", 32'(all_done), 32'd0);
    tick();
    check("t5_finished", 32'(all_done), 32'd1);
    read_entry("t5_b1", 4'd1, 32'd0, 2'd0, 32'd0);

    // Reset in the middle of solver 2's run
    set_stub(0, 3, 32'h20, 1'b0);
    set_stub(1, 3, 32'h21, 1'b0);
    set_stub(2, 0, 32'h22, 1'b0);
    set_stub(3, 3, 32'h23, 1'b0);
    start_batch(4'hF);
    wait_rst(4'b1011, 100);
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6_solver_rst", 32'(solver_rst), 32'hF);
    check("t6_busy", 32'(busy), 32'd0);
    read_entry("t6_b0", 4'd0, 32'd0, 2'd0, 32'd0);
    rst = 1'b0;
    tick();

    // Rerun after reset; a start pulse during RUN must be ignored
    set_stub(2, 5, 32'h22, 1'b0);
    start_batch(4'hF);
    wait_rst(4'b1110, 50);
    start_batch(4'b0001);
    run_batch(200, order, nrel, overlap);
    check("t7_order", 32'(order), 32'h0123);
    check("t7_overlap", 32'(overlap), 32'd0);
    read_entry("t7_b0", 4'd0, 32'h20, 2'd1, 32'd3);
    read_entry("t7_b2", 4'd2, 32'h22, 2'd1, 32'd5);
    read_entry("t7_b3", 4'd3, 32'h23, 2'd1, 32'd3);
    read_entry("t7_oob", 4'd15, 32'd0, 2'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
